// File: rtl/uart6551_dma.sv
// Wishbone initiator servicing a uart6551: programs CTRL/CMD after reset, then moves bytes on DRQ.
// Optional timeout watchdog and sticky err_o enabled by defining UART6551_DMA_TIMEOUT_EN.
module uart6551_dma #(
  parameter logic [31:0] pCtrlInit = 32'h0100_001E,
  parameter logic [31:0] pCmdInit  = 32'h0000_0009,
  parameter int unsigned pHoldoff  = 4,
  parameter int unsigned pTimeout  = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  output logic [3:0]  sel_o,
  output logic [1:0]  adr_o,
  output logic [31:0] dat_o,
  input  logic [31:0] dat_i,
  input  logic        ack_i,
  input  logic        rxDRQ_i,
  input  logic        txDRQ_i,
  input  logic        en_i,
  input  logic [7:0]  tx_dat_i,
  input  logic        tx_vld_i,
  output logic        tx_rdy_o,
  output logic [7:0]  rx_dat_o,
  output logic        rx_vld_o,
  input  logic        rx_rdy_i,
  output logic        init_done_o,
  output logic        err_o,
  input  logic        err_clr_i
);

  typedef enum logic [2:0] {
    S_INIT_CTRL,
    S_INIT_CMD,
    S_IDLE,
    S_RX_RD,
    S_TX_WR,
    S_HOLD
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(pHoldoff - 1);

  state_t      r_state;
  logic        r_cyc;
  logic        r_we;
  logic [3:0]  r_sel;
  logic [1:0]  r_adr;
  logic [31:0] r_dat;
  logic [7:0]  r_rx_dat;
  logic        r_rx_vld;
  logic        r_init_done;
  logic [3:0]  r_hold;

  logic w_idle_en;
  logic w_rx_launch;
  logic w_tx_rdy;
  logic w_tx_launch;
  logic w_ack;
  logic w_timeout;
  logic w_unused;

  // Rx always wins the arbitration; tx is only offered when no read starts this cycle.
  assign w_idle_en   = (r_state == S_IDLE) && en_i;
  assign w_rx_launch = w_idle_en && rxDRQ_i && !r_rx_vld;
  assign w_tx_rdy    = w_idle_en && txDRQ_i && !w_rx_launch;
  assign w_tx_launch = w_tx_rdy && tx_vld_i;
  assign w_ack       = r_cyc && ack_i;
  assign w_unused    = ^{dat_i[31:8], err_clr_i};

`ifdef UART6551_DMA_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(pTimeout - 1);

  logic [7:0] r_tmo;
  logic       r_err;

  assign w_timeout = r_cyc && !ack_i && (r_tmo == TMO_LAST);

  // NOTE: reset is synchronous, so it lives inside the clocked block and needs no sensitivity entry.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tmo <= '0;
      r_err <= 1'b0;
    end else begin
      r_tmo <= (!r_cyc || ack_i) ? 8'd0 : r_tmo + 8'd1;
      if (w_timeout)      r_err <= 1'b1;
      else if (err_clr_i) r_err <= 1'b0;
    end
  end

  assign err_o = r_err;
`else
  assign w_timeout = 1'b0;
  assign err_o     = 1'b0;
`endif

  // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_INIT_CTRL;
      r_cyc       <= 1'b0;
      r_we        <= 1'b0;
      r_sel       <= '0;
      r_adr       <= '0;
      r_dat       <= '0;
      r_rx_dat    <= '0;
      r_rx_vld    <= 1'b0;
      r_init_done <= 1'b0;
      r_hold      <= '0;
    end else begin
      if (r_rx_vld && rx_rdy_i) r_rx_vld <= 1'b0;

      case (r_state)
        S_INIT_CTRL: begin
          if (!r_cyc) begin
            r_cyc <= 1'b1;
            r_we  <= 1'b1;
            r_adr <= 2'd3;
            r_sel <= 4'hF;
            r_dat <= pCtrlInit;
          end else if (w_ack) begin
            r_cyc   <= 1'b0;
            r_state <= S_INIT_CMD;
          end else if (w_timeout) begin
            r_cyc <= 1'b0;
          end
        end

        S_INIT_CMD: begin
          if (!r_cyc) begin
            r_cyc <= 1'b1;
            r_we  <= 1'b1;
            r_adr <= 2'd2;
            r_sel <= 4'hF;
            r_dat <= pCmdInit;
          end else if (w_ack) begin
            r_cyc       <= 1'b0;
            r_init_done <= 1'b1;
            r_hold      <= '0;
            r_state     <= S_HOLD;
          end else if (w_timeout) begin
            r_cyc <= 1'b0;
          end
        end

        S_IDLE: begin
          if (w_rx_launch) begin
            r_cyc   <= 1'b1;
            r_we    <= 1'b0;
            r_adr   <= 2'd0;
            r_sel   <= 4'h1;
            r_state <= S_RX_RD;
          end else if (w_tx_launch) begin
            r_cyc   <= 1'b1;
            r_we    <= 1'b1;
            r_adr   <= 2'd0;
            r_sel   <= 4'h1;
            r_dat   <= {24'h0, tx_dat_i};
            r_state <= S_TX_WR;
          end
        end

        S_RX_RD: begin
          if (w_ack) begin
            r_cyc    <= 1'b0;
            r_rx_dat <= dat_i[7:0];
            r_rx_vld <= 1'b1;
            r_hold   <= '0;
            r_state  <= S_HOLD;
          end else if (w_timeout) begin
            r_cyc   <= 1'b0;
            r_hold  <= '0;
            r_state <= S_HOLD;
          end
        end

        S_TX_WR: begin
          if (w_ack || w_timeout) begin
            r_cyc   <= 1'b0;
            r_hold  <= '0;
            r_state <= S_HOLD;
          end
        end

        S_HOLD: begin
          // Gives the UART time to drop its DRQ before it is sampled again.
          if (r_hold == HOLD_LAST) r_state <= S_IDLE;
          else                     r_hold  <= r_hold + 4'd1;
        end

        default: r_state <= S_INIT_CTRL;
      endcase
    end
  end

  assign cyc_o       = r_cyc;
  assign stb_o       = r_cyc;
  assign we_o        = r_we;
  assign sel_o       = r_sel;
  assign adr_o       = r_adr;
  assign dat_o       = r_dat;
  assign tx_rdy_o    = w_tx_rdy;
  assign rx_dat_o    = r_rx_dat;
  assign rx_vld_o    = r_rx_vld;
  assign init_done_o = r_init_done;

endmodule

// File: tb/tb_uart6551_dma.sv
// Self-checking bench for uart6551_dma: scripted init/rx/tx/timeout/reset cases plus randomized DRQ traffic.
`timescale 1ns/1ps
module tb_uart6551_dma;

  localparam int          HOLDOFF   = 4;
  localparam int          TIMEOUT   = 16;
  localparam logic [31:0] CTRL_INIT = 32'h0100_001E;
  localparam logic [31:0] CMD_INIT  = 32'h0000_0009;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        cyc_o, stb_o, we_o;
  logic [3:0]  sel_o;
  logic [1:0]  adr_o;
  logic [31:0] dat_o;
  logic [31:0] dat_i = '0;
  logic        ack_i = 1'b0;
  logic        rxDRQ_i = 1'b0, txDRQ_i = 1'b0, en_i = 1'b1;
  logic [7:0]  tx_dat_i = '0;
  logic        tx_vld_i = 1'b0, tx_rdy_o;
  logic [7:0]  rx_dat_o;
  logic        rx_vld_o;
  logic        rx_rdy_i = 1'b1;
  logic        init_done_o, err_o;
  logic        err_clr_i = 1'b0;

  uart6551_dma #(
    .pCtrlInit(CTRL_INIT), .pCmdInit(CMD_INIT), .pHoldoff(HOLDOFF), .pTimeout(TIMEOUT)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o),
    .sel_o(sel_o), .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i), .ack_i(ack_i),
    .rxDRQ_i(rxDRQ_i), .txDRQ_i(txDRQ_i), .en_i(en_i),
    .tx_dat_i(tx_dat_i), .tx_vld_i(tx_vld_i), .tx_rdy_o(tx_rdy_o),
    .rx_dat_o(rx_dat_o), .rx_vld_o(rx_vld_o), .rx_rdy_i(rx_rdy_i),
    .init_done_o(init_done_o), .err_o(err_o), .err_clr_i(err_clr_i)
  );

  always #5 clk_i = ~clk_i;

  int cyc_n  = 0;
  int n_xfer = 0;
  always @(posedge clk_i) begin
    cyc_n <= cyc_n + 1;
    if (tx_rdy_o && tx_vld_i) n_xfer <= n_xfer + 1;
  end

  int n_checks = 0;
  int n_errors = 0;
  int last_ack  = 0;
  int last_rise = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for the DUT to start a bus cycle; called and returns on a negedge.
  task automatic wait_cyc(input string tag, output bit ok);
    int n = 0;
    while (cyc_o !== 1'b1 && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    check({tag, "_start"}, {31'h0, cyc_o}, 32'h1);
    ok        = (cyc_o === 1'b1);
    last_rise = cyc_n;
  endtask

  // Acts as the UART slave for one expected transaction.
  task automatic wb_txn(input string tag, input logic exp_we, input logic [1:0] exp_adr,
                        input logic [3:0] exp_sel, input logic [31:0] exp_dat,
                        input int delay, input logic [31:0] rdata);
    bit ok;
    wait_cyc(tag, ok);
    if (!ok) return;
    check({tag, "_stb"}, {31'h0, stb_o}, 32'h1);
    check({tag, "_we"},  {31'h0, we_o}, {31'h0, exp_we});
    check({tag, "_adr"}, {30'h0, adr_o}, {30'h0, exp_adr});
    check({tag, "_sel"}, {28'h0, sel_o}, {28'h0, exp_sel});
    if (exp_we) begin
      check({tag, "_dat"}, dat_o, exp_dat);
      tx_vld_i = 1'b0;
      txDRQ_i  = 1'b0;
    end
    repeat (delay) @(negedge clk_i);
    check({tag, "_stable"}, {24'h0, cyc_o, adr_o, sel_o, we_o}, {24'h0, 1'b1, exp_adr, exp_sel, exp_we});
    ack_i    = 1'b1;
    dat_i    = rdata;
    last_ack = cyc_n;
    if (!exp_we) rxDRQ_i = 1'b0;
    @(negedge clk_i);
    ack_i = 1'b0;
    dat_i = $urandom;
    check({tag, "_drop"}, {31'h0, cyc_o}, 32'h0);
    if (!exp_we) begin
      check({tag, "_rxvld"}, {31'h0, rx_vld_o}, 32'h1);
      check({tag, "_rxdat"}, {24'h0, rx_dat_o}, {24'h0, rdata[7:0]});
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ok;
    int          busy;
    int          x0;
    int          prev_ack;
    logic [7:0]  b;
    logic [31:0] rd;
    bit          rx, tx;

    repeat (3) @(negedge clk_i);
    check("rst_cyc",  {31'h0, cyc_o}, 32'h0);
    check("rst_stb",  {31'h0, stb_o}, 32'h0);
    check("rst_bus",  {25'h0, we_o, sel_o, adr_o}, 32'h0);
    check("rst_dat",  dat_o, 32'h0);
    check("rst_rx",   {23'h0, rx_vld_o, rx_dat_o}, 32'h0);
    check("rst_flag", {29'h0, init_done_o, err_o, tx_rdy_o}, 32'h0);

    // Init must precede rx service even with a DRQ already pending.
    rxDRQ_i  = 1'b1;
    rx_rdy_i = 1'b0;
    rst_i    = 1'b0;
    @(negedge clk_i);
    wb_txn("init_ctrl", 1'b1, 2'd3, 4'hF, CTRL_INIT, 2, $urandom);
    check("init_done_mid", {31'h0, init_done_o}, 32'h0);
    wb_txn("init_cmd", 1'b1, 2'd2, 4'hF, CMD_INIT, 2, $urandom);
    check("init_done", {31'h0, init_done_o}, 32'h1);

    prev_ack = last_ack;
    wb_txn("rx_a5", 1'b0, 2'd0, 4'h1, 32'h0, 1, 32'h0000_00A5);
    check("rx_spacing", last_rise - prev_ack, HOLDOFF + 2);

    // rx_vld held: a stuck rxDRQ must not cause further reads.
    rxDRQ_i = 1'b1;
    busy = 0;
    repeat (HOLDOFF + 8) begin
      @(negedge clk_i);
      if (cyc_o) busy++;
    end
    check("rx_block_cyc", busy, 0);
    check("rx_held_vld", {31'h0, rx_vld_o}, 32'h1);
    check("rx_held_dat", {24'h0, rx_dat_o}, 32'hA5);

    x0 = n_xfer;
    txDRQ_i  = 1'b1;
    tx_vld_i = 1'b1;
    tx_dat_i = 8'h3C;
    wb_txn("tx_3c", 1'b1, 2'd0, 4'h1, 32'h0000_003C, 0, $urandom);
    check("tx_3c_xfer", n_xfer - x0, 1);

    rx_rdy_i = 1'b1;
    @(negedge clk_i);
    check("rx_drain", {31'h0, rx_vld_o}, 32'h0);
    wb_txn("rx_after", 1'b0, 2'd0, 4'h1, 32'h0, 3, $urandom);

    // en_i low blocks new launches.
    en_i    = 1'b0;
    rxDRQ_i = 1'b1;
    busy = 0;
    repeat (HOLDOFF + 10) begin
      @(negedge clk_i);
      if (cyc_o) busy++;
    end
    check("en_block", busy, 0);
    en_i = 1'b1;
    wb_txn("en_rx", 1'b0, 2'd0, 4'h1, 32'h0, 0, $urandom);

    // Randomized DRQ traffic against a transaction-level model: rx first, then tx.
    for (int i = 0; i < 16; i++) begin
      rx = 1'($urandom_range(0, 1));
      tx = 1'($urandom_range(0, 1));
      if (!rx && !tx) tx = 1'b1;
      b  = 8'($urandom);
      rd = $urandom;
      x0 = n_xfer;
      prev_ack = last_ack;
      rxDRQ_i  = rx;
      txDRQ_i  = tx;
      tx_vld_i = 1'b1;
      tx_dat_i = b;
      if (rx) wb_txn("rand_rx", 1'b0, 2'd0, 4'h1, 32'h0, $urandom_range(0, 4), rd);
      if (rx) prev_ack = last_ack;
      if (tx) wb_txn("rand_tx", 1'b1, 2'd0, 4'h1, {24'h0, b}, $urandom_range(0, 4), $urandom);
      if (rx && tx) check("rand_spacing", last_rise - prev_ack, HOLDOFF + 2);
      check("rand_xfer", n_xfer - x0, tx ? 1 : 0);
      tx_vld_i = 1'b0;
    end

    // No ack: watchdog behaviour depends on the build option.
    rxDRQ_i = 1'b1;
    wait_cyc("tmo", ok);
    repeat (TIMEOUT - 1) @(negedge clk_i);
    check("tmo_before", {31'h0, cyc_o}, 32'h1);
    @(negedge clk_i);
`ifdef UART6551_DMA_TIMEOUT_EN
    rxDRQ_i = 1'b0;
    check("tmo_cyc", {31'h0, cyc_o}, 32'h0);
    check("tmo_err", {31'h0, err_o}, 32'h1);
    check("tmo_rxvld", {31'h0, rx_vld_o}, 32'h0);
    err_clr_i = 1'b1;
    @(negedge clk_i);
    err_clr_i = 1'b0;
    check("tmo_clr", {31'h0, err_o}, 32'h0);
`else
    check("notmo_cyc", {31'h0, cyc_o}, 32'h1);
    repeat (20) @(negedge clk_i);
    check("notmo_cyc_late", {31'h0, cyc_o}, 32'h1);
    err_clr_i = 1'b1;
    @(negedge clk_i);
    err_clr_i = 1'b0;
    check("notmo_err", {31'h0, err_o}, 32'h0);
    wb_txn("notmo_finish", 1'b0, 2'd0, 4'h1, 32'h0, 0, $urandom);
`endif

    // Reset in the middle of a read.
    repeat (HOLDOFF + 2) @(negedge clk_i);
    rxDRQ_i = 1'b1;
    wait_cyc("rst_rd", ok);
    rst_i = 1'b1;
    @(negedge clk_i);
    check("rstmid_cyc", {31'h0, cyc_o}, 32'h0);
    check("rstmid_rxvld", {31'h0, rx_vld_o}, 32'h0);
    check("rstmid_init", {31'h0, init_done_o}, 32'h0);
    rxDRQ_i = 1'b0;
    rst_i   = 1'b0;
    @(negedge clk_i);
    wb_txn("reinit_ctrl", 1'b1, 2'd3, 4'hF, CTRL_INIT, 1, $urandom);
    wb_txn("reinit_cmd", 1'b1, 2'd2, 4'hF, CMD_INIT, 0, $urandom);
    check("reinit_done", {31'h0, init_done_o}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
